drum_xfer_sequencer: RTL and testbench



---
 rtl/g15_drum_pkg.sv | 28 ++
 rtl/drum_position_counter.sv | 47 ++++
 rtl/drum_xfer_sequencer.sv | 141 ++++++++++++++
 tb/tb_drum_xfer_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/g15_drum_pkg.sv
// Shared drum geometry, transfer FSM states and line-select decode.
package g15_drum_pkg;

    localparam int WORD_BITS  = 29;   // bit times per word
    localparam int DRUM_WORDS = 108;  // words per revolution
    localparam int BIT_W      = 5;    // bit-time counter width
    localparam int WORD_W     = 7;    // word-time counter width
    localparam int REM_W      = 12;   // remaining-bit-time counter width (3132 max)

    localparam logic [2:0] LINE_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {IDLE, WAIT, XFER} xfer_state_t;

    // Line number -> {S0/D0, S1/D1, SU/DU, SV/DV, SW/DW, SX/DX}
    function automatic logic [5:0] line_sel(input logic [2:0] line);
        case (line)
            3'd0:    return 6'b10_1000;
            3'd1:    return 6'b10_0100;
            3'd2:    return 6'b10_0010;
            3'd3:    return 6'b10_0001;
            3'd4:    return 6'b01_1000;
            3'd5:    return 6'b01_0100;
            3'd6:    return 6'b01_0010;
            default: return 6'b00_0000;
        endcase
    endfunction

endpackage

// File: rtl/drum_position_counter.sv
// Free-running drum angular position: bit time 0..28 within word time 0..107.
module drum_position_counter
    import g15_drum_pkg::BIT_W, g15_drum_pkg::WORD_W;
#(
    parameter int WORD_BITS  = g15_drum_pkg::WORD_BITS,
    parameter int DRUM_WORDS = g15_drum_pkg::DRUM_WORDS
) (
    input  logic              CLOCK,
    input  logic              rst,
    output logic [BIT_W-1:0]  BIT_T,
    output logic [WORD_W-1:0] WORD_T,
    output logic              T0,
    output logic              T28
);

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(DRUM_WORDS - 1);

    logic [BIT_W-1:0]  bit_nx;
    logic [WORD_W-1:0] word_nx;
    logic              wrap;

    // Next position: bit time always advances, word time advances on bit wrap
    always_comb begin
        wrap    = (BIT_T == BIT_LAST);
        bit_nx  = wrap ? '0 : BIT_T + 1'b1;
        word_nx = WORD_T;
        if (wrap)
            word_nx = (WORD_T == WORD_LAST) ? '0 : WORD_T + 1'b1;
    end

    // Position registers; T0/T28 are registered decodes that always agree with BIT_T
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            BIT_T  <= '0;
            WORD_T <= '0;
            T0     <= 1'b1;
            T28    <= 1'b0;
        end else begin
            BIT_T  <= bit_nx;
            WORD_T <= word_nx;
            T0     <= (bit_nx == '0);
            T28    <= (bit_nx == BIT_LAST);
        end
    end

endmodule

// File: rtl/drum_xfer_sequencer.sv
// Block-transfer scheduler: waits for the start word, then drives the line
// selects for exactly count x WORD_BITS bit times.
module drum_xfer_sequencer
    import g15_drum_pkg::BIT_W, g15_drum_pkg::WORD_W, g15_drum_pkg::REM_W,
           g15_drum_pkg::LINE_ILLEGAL, g15_drum_pkg::xfer_state_t,
           g15_drum_pkg::IDLE, g15_drum_pkg::WAIT, g15_drum_pkg::XFER,
           g15_drum_pkg::line_sel;
#(
    parameter int WORD_BITS  = g15_drum_pkg::WORD_BITS,
    parameter int DRUM_WORDS = g15_drum_pkg::DRUM_WORDS
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              REQ,
    input  logic [2:0]        REQ_LINE,
    input  logic [6:0]        REQ_WORD,
    input  logic [6:0]        REQ_COUNT,
    input  logic              REQ_WRITE,
    input  logic              ABORT,
    output logic              ACK,
    output logic              ERR,
    output logic              BUSY,
    output logic              DONE,
    output logic [BIT_W-1:0]  BIT_T,
    output logic [WORD_W-1:0] WORD_T,
    output logic              T0,
    output logic              T28,
    output logic              D0, D1, DU, DV, DW, DX, TR,
    output logic              S0, S1, SU, SV, SW, SX
);

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(DRUM_WORDS - 1);
    localparam logic [WORD_W-1:0] FULL_REV  = WORD_W'(DRUM_WORDS);

    xfer_state_t       state, state_nx;
    logic [2:0]        line_q;
    logic              write_q;
    logic [WORD_W-1:0] start_q;
    logic [REM_W-1:0]  remain;
    logic [WORD_W-1:0] count_words, word_inc;
    logic              start_hit, accept, ack_nx, err_nx, done_nx, in_win;
    logic [5:0]        pat;

    drum_position_counter #(
        .WORD_BITS  (WORD_BITS),
        .DRUM_WORDS (DRUM_WORDS)
    ) u_pos (
        .CLOCK  (CLOCK),
        .rst    (rst),
        .BIT_T  (BIT_T),
        .WORD_T (WORD_T),
        .T0     (T0),
        .T28    (T28)
    );

    // Count clamp, and look-ahead: next cycle is bit 0 of the latched start word
    always_comb begin
        count_words = (REQ_COUNT == '0 || REQ_COUNT > FULL_REV) ? FULL_REV : REQ_COUNT;
        word_inc    = (WORD_T == WORD_LAST) ? '0 : WORD_T + 1'b1;
        start_hit   = (BIT_T == BIT_LAST) && (word_inc == start_q);
        in_win      = (state_nx == XFER);
        pat         = line_sel(line_q);
    end

    // Next-state and one-cycle pulse decisions; ABORT beats window completion
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: if (REQ) begin
                if (REQ_LINE != LINE_ILLEGAL) begin
                    accept   = 1'b1;
                    ack_nx   = 1'b1;
                    state_nx = WAIT;
                end else begin
                    err_nx   = 1'b1;
                end
            end
            WAIT: begin
                if (ABORT)          state_nx = IDLE;
                else if (start_hit) state_nx = XFER;
            end
            XFER: begin
                if (ABORT) begin
                    state_nx = IDLE;
                end else if (remain == REM_W'(1)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, request latch, remaining-bit-time counter and status flags
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state   <= IDLE;
            line_q  <= '0;
            write_q <= 1'b0;
            start_q <= '0;
            remain  <= '0;
            ACK     <= 1'b0;
            ERR     <= 1'b0;
            DONE    <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state <= state_nx;
            ACK   <= ack_nx;
            ERR   <= err_nx;
            DONE  <= done_nx;
            BUSY  <= (state_nx != IDLE);
            if (accept) begin
                line_q  <= REQ_LINE;
                write_q <= REQ_WRITE;
                start_q <= REQ_WORD;
                remain  <= REM_W'(count_words * WORD_BITS);
            end else if (state == XFER) begin
                remain  <= remain - 1'b1;
            end
        end
    end

    // Select strobes follow the next state so they line up with the window cycles
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            {D0, D1, DU, DV, DW, DX} <= '0;
            TR                       <= 1'b0;
            {S0, S1, SU, SV, SW, SX} <= '0;
        end else begin
            {D0, D1, DU, DV, DW, DX} <= (in_win && write_q)  ? pat : '0;
            TR                       <= in_win && write_q;
            {S0, S1, SU, SV, SW, SX} <= (in_win && !write_q) ? pat : '0;
        end
    end

endmodule

// File: tb/tb_drum_xfer_sequencer.sv
// Scoreboard bench: stimulus queues expected events, a monitor pops and compares.
module tb_drum_xfer_sequencer;

    logic       CLOCK = 1'b0;
    logic       rst = 1'b1;
    logic       REQ = 1'b0;
    logic [2:0] REQ_LINE = '0;
    logic [6:0] REQ_WORD = '0;
    logic [6:0] REQ_COUNT = '0;
    logic       REQ_WRITE = 1'b0;
    logic       ABORT = 1'b0;
    logic       ACK, ERR, BUSY, DONE, T0, T28;
    logic [4:0] BIT_T;
    logic [6:0] WORD_T;
    logic       D0, D1, DU, DV, DW, DX, TR, S0, S1, SU, SV, SW, SX;

    always #5 CLOCK = ~CLOCK;

    drum_xfer_sequencer dut (
        .CLOCK(CLOCK), .rst(rst), .REQ(REQ), .REQ_LINE(REQ_LINE), .REQ_WORD(REQ_WORD),
        .REQ_COUNT(REQ_COUNT), .REQ_WRITE(REQ_WRITE), .ABORT(ABORT),
        .ACK(ACK), .ERR(ERR), .BUSY(BUSY), .DONE(DONE), .BIT_T(BIT_T), .WORD_T(WORD_T),
        .T0(T0), .T28(T28), .D0(D0), .D1(D1), .DU(DU), .DV(DV), .DW(DW), .DX(DX), .TR(TR),
        .S0(S0), .S1(S1), .SU(SU), .SV(SV), .SW(SW), .SX(SX)
    );

    // {D0,D1,DU,DV,DW,DX,TR, S0,S1,SU,SV,SW,SX}
    localparam logic [12:0] P_W5 = 13'b0101001_000000;  // D1 DV TR
    localparam logic [12:0] P_R2 = 13'b0000000_100010;  // S0 SW
    localparam logic [12:0] P_W0 = 13'b1010001_000000;  // D0 DU TR
    localparam logic [12:0] P_R6 = 13'b0000000_010010;  // S1 SW
    localparam logic [12:0] P_W3 = 13'b1000011_000000;  // D0 DX TR
    localparam logic [12:0] P_W4 = 13'b0110001_000000;  // D1 DU TR
    localparam logic [12:0] P_R1 = 13'b0000000_100100;  // S0 SV

    typedef enum {EV_ACK, EV_ERR, EV_SEL, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          word;   // -1: position not checked
        int          bitt;
        logic [12:0] pat;
        logic        busy;
        int          len;    // -1: length not checked
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 0;
    int          cyc = 0;
    int          sel_cyc = 0;
    logic [12:0] sel_prev = '0;
    logic [12:0] sel_now;

    assign sel_now = {D0, D1, DU, DV, DW, DX, TR, S0, S1, SU, SV, SW, SX};

    task automatic check(input bit ok, input string name, input string detail);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input int w, input int b,
                             input logic [12:0] p, input logic bz, input int len);
        ev_t e;
        e.kind = k; e.word = w; e.bitt = b; e.pat = p; e.busy = bz; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input int len);
        ev_t e;
        bit  ok;
        if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_event", $sformatf("got %s at w%0d b%0d sel=%b, required none",
                  k.name(), WORD_T, BIT_T, sel_now));
            return;
        end
        e  = exp_q.pop_front();
        ok = (e.kind == k) && (e.busy == BUSY)
          && (e.word < 0 || (e.word == int'(WORD_T) && e.bitt == int'(BIT_T)))
          && (k != EV_SEL || e.pat == sel_now)
          && (e.len < 0 || e.len == len);
        check(ok, $sformatf("event_%s", e.kind.name()),
              $sformatf("got %s w%0d b%0d sel=%b busy=%b len=%0d, required %s w%0d b%0d sel=%b busy=%b len=%0d",
                        k.name(), WORD_T, BIT_T, sel_now, BUSY, len,
                        e.kind.name(), e.word, e.bitt, e.pat, e.busy, e.len));
    endtask

    // Monitor: per-cycle decode invariants plus event detection for the scoreboard
    initial forever begin
        @(negedge CLOCK);
        if (mon_en) begin
            cyc++;
            check(T0 == (BIT_T == 5'd0) && T28 == (BIT_T == 5'd28), "pos_decode",
                  $sformatf("got T0=%b T28=%b at BIT_T=%0d", T0, T28, BIT_T));
            check(!((|sel_now[12:6]) && (|sel_now[5:0])), "sel_exclusive",
                  $sformatf("got sel=%b, required write/read groups not both high", sel_now));
            if (ACK) observe(EV_ACK, -1);
            if (ERR) observe(EV_ERR, -1);
            if (sel_now != sel_prev) begin
                observe(EV_SEL, cyc - sel_cyc);
                sel_cyc  = cyc;
                sel_prev = sel_now;
            end
            if (DONE) observe(EV_DONE, -1);
        end
    end

    task automatic wait_pos(input int w, input int b);
        int n = 0;
        do begin
            @(negedge CLOCK);
            n++;
        end while (!(int'(WORD_T) == w && int'(BIT_T) == b) && n < 4000);
        check(int'(WORD_T) == w && int'(BIT_T) == b, "wait_pos_timeout",
              $sformatf("got w%0d b%0d, required w%0d b%0d", WORD_T, BIT_T, w, b));
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge CLOCK);
            n++;
        end while (BUSY && n < 7000);
        check(!BUSY, "wait_idle_timeout", $sformatf("got BUSY=%b, required 0", BUSY));
    endtask

    task automatic request(input int line, input int word, input int count, input bit wr,
                           input int hold);
        bit seen = 0;
        if (line == 7) expect_ev(EV_ERR, -1, -1, '0, 1'b0, -1);
        else           expect_ev(EV_ACK, -1, -1, '0, 1'b1, -1);
        REQ_LINE = 3'(line); REQ_WORD = 7'(word); REQ_COUNT = 7'(count); REQ_WRITE = wr;
        REQ = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLOCK);
            seen = ACK || ERR;
        end
        check(seen, "req_response", $sformatf("got ACK=%b ERR=%b, required a response", ACK, ERR));
        repeat (hold) @(negedge CLOCK);
        REQ = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check(!BUSY && !ACK && !ERR && !DONE && sel_now == '0, name,
              $sformatf("got BUSY=%b ACK=%b ERR=%b DONE=%b sel=%b, required all 0",
                        BUSY, ACK, ERR, DONE, sel_now));
        check(WORD_T == 7'd0 && BIT_T == 5'd0, {name, "_pos"},
              $sformatf("got w%0d b%0d, required w0 b0", WORD_T, BIT_T));
    endtask

    initial begin
        // Reset held 5 cycles
        repeat (5) @(negedge CLOCK);
        check_idle("reset");
        sel_prev = sel_now;
        mon_en   = 1;
        rst      = 1'b0;

        // Counter sweep through one full revolution
        repeat (28) @(negedge CLOCK);
        check(WORD_T == 7'd0 && BIT_T == 5'd28, "cnt_bit28", $sformatf("got w%0d b%0d, required w0 b28", WORD_T, BIT_T));
        @(negedge CLOCK);
        check(WORD_T == 7'd1 && BIT_T == 5'd0, "cnt_word1", $sformatf("got w%0d b%0d, required w1 b0", WORD_T, BIT_T));
        repeat (3102) @(negedge CLOCK);
        check(WORD_T == 7'd107 && BIT_T == 5'd28, "cnt_last", $sformatf("got w%0d b%0d, required w107 b28", WORD_T, BIT_T));
        @(negedge CLOCK);
        check(WORD_T == 7'd0 && BIT_T == 5'd0, "cnt_wrap", $sformatf("got w%0d b%0d, required w0 b0", WORD_T, BIT_T));

        // Write line 5, word 10, count 3, requested at word 2; REQ held past ACK
        wait_pos(2, 0);
        request(5, 10, 3, 1'b1, 5);
        expect_ev(EV_SEL, 10, 0, P_W5, 1'b1, -1);
        expect_ev(EV_SEL, 13, 0, '0, 1'b0, 87);
        expect_ev(EV_DONE, 13, 0, '0, 1'b0, -1);
        wait_idle();

        // Read line 2 wrapping through word 107
        request(2, 106, 4, 1'b0, 0);
        expect_ev(EV_SEL, 106, 0, P_R2, 1'b1, -1);
        expect_ev(EV_SEL, 2, 0, '0, 1'b0, 116);
        expect_ev(EV_DONE, 2, 0, '0, 1'b0, -1);
        wait_idle();

        // Illegal line
        request(7, 3, 1, 1'b1, 0);
        repeat (3) @(negedge CLOCK);
        check(!BUSY, "err_busy", $sformatf("got BUSY=%b, required 0", BUSY));

        // Count 0 -> full revolution on line 0
        request(0, 0, 0, 1'b1, 0);
        expect_ev(EV_SEL, 0, 0, P_W0, 1'b1, -1);
        expect_ev(EV_SEL, 0, 0, '0, 1'b0, 3132);
        expect_ev(EV_DONE, 0, 0, '0, 1'b0, -1);
        wait_idle();

        // Count 120 clamps to 108
        request(6, 50, 120, 1'b0, 0);
        expect_ev(EV_SEL, 50, 0, P_R6, 1'b1, -1);
        expect_ev(EV_SEL, 50, 0, '0, 1'b0, 3132);
        expect_ev(EV_DONE, 50, 0, '0, 1'b0, -1);
        wait_idle();

        // ABORT mid-window at word 11 of a line-3 write
        request(3, 10, 5, 1'b1, 0);
        expect_ev(EV_SEL, 10, 0, P_W3, 1'b1, -1);
        wait_pos(11, 5);
        expect_ev(EV_SEL, 11, 6, '0, 1'b0, 35);
        ABORT = 1'b1;
        @(negedge CLOCK);
        ABORT = 1'b0;

        // Following request is accepted
        request(4, 20, 1, 1'b1, 0);
        expect_ev(EV_SEL, 20, 0, P_W4, 1'b1, -1);
        expect_ev(EV_SEL, 21, 0, '0, 1'b0, 29);
        expect_ev(EV_DONE, 21, 0, '0, 1'b0, -1);
        wait_idle();

        // Reset during WAIT: no window may appear afterwards
        request(1, 60, 2, 1'b0, 0);
        repeat (3) @(negedge CLOCK);
        rst = 1'b1;
        @(negedge CLOCK);
        check_idle("rst_wait");
        rst = 1'b0;
        wait_pos(62, 0);

        // Reset during XFER: selects drop next cycle, no DONE
        request(1, 5, 2, 1'b0, 0);
        expect_ev(EV_SEL, 5, 0, P_R1, 1'b1, -1);
        wait_pos(5, 10);
        expect_ev(EV_SEL, 0, 0, '0, 1'b0, 11);
        rst = 1'b1;
        @(negedge CLOCK);
        check_idle("rst_xfer");
        rst = 1'b0;
        wait_pos(7, 0);

        check(exp_q.size() == 0, "pending_events",
              $sformatf("got %0d events outstanding, required 0", exp_q.size()));
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
